// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and constants for the fetch/issue sequencer.
package pc_seq_pkg;
   typedef enum logic [1:0] {FETCH, WAIT, ISSUE} state_t;
   localparam int INSTR_W = 32;
   localparam int PC_INC  = 4;
endpackage

// File: rtl/pc_incr_mux.sv
// pc_incr_mux: next-PC select, taken branch target or sequential PC, wrapping modulo 2^WIDTH.
module pc_incr_mux import pc_seq_pkg::*; #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] PC,
   input  logic [WIDTH-1:0] ImmOp,
   input  logic             PCsrc,
   output logic [WIDTH-1:0] next
);
   assign next = PCsrc ? PC + ImmOp : PC + WIDTH'(PC_INC);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: FETCH/WAIT/ISSUE instruction sequencer with stall hold and branch redirect.
// Optional FETCH_PERF_EN adds fetch_cnt/stall_cnt performance counters.
module pc_sequencer import pc_seq_pkg::*; #(
   parameter int             WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   ImmOp,
   input  logic               PCsrc,
   input  logic               stall,
   output logic               imem_req,
   output logic [WIDTH-1:0]   imem_addr,
   input  logic               imem_ready,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic [WIDTH-1:0]   PC
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        fetch_cnt,
   output logic [31:0]        stall_cnt
`endif
);
   state_t             r_state, w_state_nxt;
   logic [WIDTH-1:0]   r_fetch_pc, r_pc, w_pc_next;
   logic [INSTR_W-1:0] r_instr;
   logic               w_accept, w_capture, w_advance;

   assign w_accept  = r_state == FETCH && imem_ready;
   assign w_capture = r_state == WAIT && imem_rvalid;
   assign w_advance = r_state == ISSUE && !stall;

   pc_incr_mux #(.WIDTH(WIDTH)) u_incr (
      .PC    (r_pc),
      .ImmOp (ImmOp),
      .PCsrc (PCsrc),
      .next  (w_pc_next)
   );

   always_ff @(posedge clk) r_state <= rst ? FETCH : w_state_nxt;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         FETCH:   w_state_nxt = imem_ready  ? WAIT  : FETCH;
         WAIT:    w_state_nxt = imem_rvalid ? ISSUE : WAIT;
         ISSUE:   w_state_nxt = stall       ? ISSUE : FETCH;
         default: w_state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_VEC;
         r_pc       <= RESET_VEC;
         r_instr    <= '0;
      end else begin
         if (w_capture) begin
            r_instr <= imem_rdata;
            r_pc    <= r_fetch_pc;
         end
         if (w_advance) r_fetch_pc <= w_pc_next;
      end
   end

   // request is masked while reset is held so nothing is launched before release
   assign imem_req    = r_state == FETCH && !rst;
   assign imem_addr   = r_fetch_pc;
   assign instr       = r_instr;
   assign instr_valid = r_state == ISSUE;
   assign PC          = r_pc;

`ifdef FETCH_PERF_EN
   logic [31:0] r_fetch_cnt, r_stall_cnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_accept) r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (r_state == ISSUE && stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end
   assign fetch_cnt = r_fetch_cnt;
   assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;
   logic        clk = 0;
   logic        rst, PCsrc, stall, imem_ready, imem_rvalid;
   logic [31:0] ImmOp, imem_rdata;
   logic        imem_req, instr_valid;
   logic [31:0] imem_addr, instr, PC;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt, stall_cnt;
`endif
   int checks = 0;
   int errors = 0;

   pc_sequencer dut (
      .clk(clk), .rst(rst), .ImmOp(ImmOp), .PCsrc(PCsrc), .stall(stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr(instr), .instr_valid(instr_valid), .PC(PC)
`ifdef FETCH_PERF_EN
      , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // from FETCH: accept, then return data the following cycle; ends in ISSUE
   task automatic do_fetch(input logic [31:0] data);
      imem_ready = 1;
      step();
      imem_ready  = 0;
      imem_rvalid = 1;
      imem_rdata  = data;
      step();
      imem_rvalid = 0;
      #1;
   endtask

   initial begin
      rst = 1; PCsrc = 0; stall = 0; imem_ready = 0; imem_rvalid = 0;
      ImmOp = 0; imem_rdata = 0;
      step(); step();
      chk("rst_req", {31'b0, imem_req}, 0);
      chk("rst_valid", {31'b0, instr_valid}, 0);
      chk("rst_pc", PC, 0);
      chk("rst_instr", instr, 0);
      rst = 0; imem_ready = 1; #1;
      chk("rel_req", {31'b0, imem_req}, 1);
      chk("rel_addr", imem_addr, 0);
      chk("rel_valid", {31'b0, instr_valid}, 0);
      step();
      imem_ready = 0; #1;
      chk("wait_req", {31'b0, imem_req}, 0);
      chk("wait_valid", {31'b0, instr_valid}, 0);
      imem_rvalid = 1; imem_rdata = 32'h13;
      step();
      imem_rvalid = 0; #1;
      chk("first_instr", instr, 32'h13);
      chk("first_pc", PC, 0);
      chk("first_valid", {31'b0, instr_valid}, 1);
      // sequential walk 0 -> 4 -> 8 -> C -> 10
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("seq_addr", imem_addr, 32'(i * 4));
         chk("seq_valid", {31'b0, instr_valid}, 0);
         do_fetch(32'(i));
      end
      chk("seq_pc", PC, 32'h10);
      chk("seq_instr", instr, 32'h4);
      // backward branch from 0x10
      PCsrc = 1; ImmOp = 32'hFFFF_FFF8;
      step();
      chk("br_back", imem_addr, 32'h8);
      do_fetch(32'h20);
      chk("br_pc", PC, 32'h8);
      ImmOp = 32'h8;
      step();
      chk("br_fwd", imem_addr, 32'h10);
      do_fetch(32'h21);
      PCsrc = 0;
      step();
      chk("nobr_addr", imem_addr, 32'h14);
      // memory back-pressure in FETCH
      for (int i = 0; i < 4; i++) begin
         step();
         chk("bp_req", {31'b0, imem_req}, 1);
         chk("bp_addr", imem_addr, 32'h14);
      end
      imem_ready = 1;
      step();
      imem_ready = 0; #1;
      chk("acc_req", {31'b0, imem_req}, 0);
      step();
      chk("wait_hold_req", {31'b0, imem_req}, 0);
      chk("wait_hold_valid", {31'b0, instr_valid}, 0);
      imem_rvalid = 1; imem_rdata = 32'h35;
      step();
      imem_rvalid = 0; #1;
      chk("bp_pc", PC, 32'h14);
      chk("bp_instr", instr, 32'h35);
      // stall with PCsrc toggling
      stall = 1; ImmOp = 32'h100;
      for (int i = 0; i < 5; i++) begin
         PCsrc = i[0];
         step();
         chk("stall_instr", instr, 32'h35);
         chk("stall_pc", PC, 32'h14);
         chk("stall_valid", {31'b0, instr_valid}, 1);
         chk("stall_req", {31'b0, imem_req}, 0);
      end
`ifdef FETCH_PERF_EN
      chk("perf_fetch", fetch_cnt, 8);
      chk("perf_stall", stall_cnt, 5);
`endif
      stall = 0; PCsrc = 1;
      step();
      chk("unstall_addr", imem_addr, 32'h114);
      PCsrc = 0;
      // reset during WAIT, late response discarded
      imem_ready = 1;
      step();
      imem_ready = 0; rst = 1;
      step();
      chk("rstw_req", {31'b0, imem_req}, 0);
      rst = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD; #1;
      chk("rstw_req1", {31'b0, imem_req}, 1);
      chk("rstw_addr", imem_addr, 0);
      step();
      imem_rvalid = 0; #1;
      chk("rstw_valid", {31'b0, instr_valid}, 0);
      chk("rstw_req2", {31'b0, imem_req}, 1);
      chk("rstw_instr", instr, 0);
      // wraparound at top of address space
      do_fetch(32'h66);
      PCsrc = 1; ImmOp = 32'hFFFF_FFFC;
      step();
      chk("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
      PCsrc = 0;
      do_fetch(32'h77);
      chk("wrap_pc", PC, 32'hFFFF_FFFC);
      step();
      chk("wrap_addr", imem_addr, 0);
`ifdef FETCH_PERF_EN
      chk("perf_fetch2", fetch_cnt, 2);
      chk("perf_stall2", stall_cnt, 0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
